disc_request_arbiter: RTL

- Shares one final-stage discriminator scorer (32 x Q8.8 in, Q8.8 score + REAL/FAKE decision out, start/done handshake) between two requesters: the real-sample path (source 0) and the generator-output path (source 1).
- Arbitrates round-robin and latches the winner's vector.
- Pulses the scorer's start, waits for its done, and returns the score and decision tagged with the source.
- Includes a watchdog timeout so a hung scorer cannot stall the training loop.

---
 rtl/disc_request_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/disc_request_arbiter.sv
// Round-robin arbiter sharing one discriminator scorer between the real-sample and generator paths.
// Optional statistics counters are built only when DISC_ARB_STATS_EN is defined.
module disc_request_arbiter #(
   parameter int unsigned N_IN    = 32,
   parameter int unsigned DW      = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_real,
   input  logic [N_IN*DW-1:0]   data_real_flat,
   input  logic                 req_fake,
   input  logic [N_IN*DW-1:0]   data_fake_flat,
   output logic                 grant_real,
   output logic                 grant_fake,
   output logic                 busy,
   output logic                 disc_start,
   output logic [N_IN*DW-1:0]   disc_flat_input,
   input  logic [DW-1:0]        disc_score,
   input  logic                 disc_decision,
   input  logic                 disc_done,
   output logic                 result_valid,
   output logic                 result_src,
   output logic [DW-1:0]        result_score,
   output logic                 result_decision,
   output logic                 result_timeout,
   output logic [15:0]          stat_real_ok,
   output logic [15:0]          stat_fake_ok,
   output logic [15:0]          stat_timeouts
);

   typedef enum logic [1:0] {IDLE, START, WAIT, REPORT} state_t;

   state_t     state_q;
   logic       src_q;
   logic       rr_q;
   logic       done_q;
   logic [7:0] timer_q;
   logic       pick_fake;
   logic       done_edge;

   // Fake path wins when it is the only requester, or on a tie when the pointer favours it.
   always_comb begin
      pick_fake = req_fake && (!req_real || rr_q);
      done_edge = disc_done && !done_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q         <= IDLE;
         src_q           <= 1'b0;
         rr_q            <= 1'b0;
         done_q          <= 1'b0;
         timer_q         <= '0;
         grant_real      <= 1'b0;
         grant_fake      <= 1'b0;
         busy            <= 1'b0;
         disc_start      <= 1'b0;
         disc_flat_input <= '0;
         result_valid    <= 1'b0;
         result_src      <= 1'b0;
         result_score    <= '0;
         result_decision <= 1'b0;
         result_timeout  <= 1'b0;
      end else begin
         done_q       <= disc_done;
         grant_real   <= 1'b0;
         grant_fake   <= 1'b0;
         disc_start   <= 1'b0;
         result_valid <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_real || req_fake) begin
                  src_q           <= pick_fake;
                  disc_flat_input <= pick_fake ? data_fake_flat : data_real_flat;
                  grant_real      <= !pick_fake;
                  grant_fake      <= pick_fake;
                  disc_start      <= 1'b1;
                  busy            <= 1'b1;
                  state_q         <= START;
               end
            end
            START: begin
               timer_q <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // A done edge takes priority over a watchdog expiry in the same cycle.
               if (done_edge) begin
                  result_score    <= disc_score;
                  result_decision <= disc_decision;
                  result_timeout  <= 1'b0;
                  result_src      <= src_q;
                  result_valid    <= 1'b1;
                  state_q         <= REPORT;
               end else if (timer_q == 8'(TIMEOUT - 1)) begin
                  result_score    <= '0;
                  result_decision <= 1'b0;
                  result_timeout  <= 1'b1;
                  result_src      <= src_q;
                  result_valid    <= 1'b1;
                  state_q         <= REPORT;
               end else begin
                  timer_q <= timer_q + 8'd1;
               end
            end
            REPORT: begin
               rr_q    <= ~src_q;
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DISC_ARB_STATS_EN
   logic [15:0] real_ok_q;
   logic [15:0] fake_ok_q;
   logic [15:0] timeouts_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         real_ok_q  <= '0;
         fake_ok_q  <= '0;
         timeouts_q <= '0;
      end else if (state_q == REPORT) begin
         if (result_timeout) begin
            if (timeouts_q != '1) timeouts_q <= timeouts_q + 16'd1;
         end else if (!result_src && result_decision) begin
            if (real_ok_q != '1) real_ok_q <= real_ok_q + 16'd1;
         end else if (result_src && !result_decision) begin
            if (fake_ok_q != '1) fake_ok_q <= fake_ok_q + 16'd1;
         end
      end
   end

   assign stat_real_ok  = real_ok_q;
   assign stat_fake_ok  = fake_ok_q;
   assign stat_timeouts = timeouts_q;
`else
   assign stat_real_ok  = '0;
   assign stat_fake_ok  = '0;
   assign stat_timeouts = '0;
`endif

endmodule
